alu_issue_ctrl: RTL and testbench

Multi-cycle issue/writeback controller that drives the 8-bit ALU (A, B, ALU_Code in; ALU_Out, Carry, isZero back) from 16-bit register-register instructions. It holds an 8-entry x 8-bit register file, decodes each accepted instruction, presents operands and opcode to the ALU, then captures the result and flags.
It sits between the instruction source (valid/ready handshake) and the combinational ALU. It is the ALU's initiator side.

---
 rtl/alu_issue_if.sv | 12 +
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Instruction handshake between an instruction source and alu_issue_ctrl.
//   Instr_Valid : source has an instruction on Instr
//   Instr_Ready : controller can accept this cycle
//   Instr       : [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] unused
interface alu_issue_if;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [15:0] Instr;

    modport master (output Instr_Valid, output Instr, input  Instr_Ready);
    modport slave  (input  Instr_Valid, input  Instr, output Instr_Ready);
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/writeback controller for an 8-bit combinational ALU.
// Accepts one register-register instruction per 3 cycles (IDLE -> OPER -> WB),
// holds an 8 x 8 register file, drives operands/opcode to the ALU in OPER and
// writes back result and flags at the OPER exit edge.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   instr_if (slave)           : Instr_Valid / Instr_Ready / Instr
//   Load_En/Load_Addr/Load_Data: external rf write, honoured only in IDLE
//   Dbg_Addr/Dbg_Data          : combinational rf observation port
//   ALU_A/ALU_B/ALU_Code       : operands and opcode to the ALU
//   ALU_Out/ALU_Carry/ALU_Zero : ALU result and flags
//   Result/Carry_Flag/Zero_Flag: last written-back result and flags
//   Done                       : one-cycle pulse while in WB
module alu_issue_ctrl #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_if.slave        instr_if,
    input  logic              Load_En,
    input  logic [2:0]        Load_Addr,
    input  logic [DATA_W-1:0] Load_Data,
    input  logic [2:0]        Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [2:0]        ALU_Code,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic              ALU_Carry,
    input  logic              ALU_Zero,
    output logic [DATA_W-1:0] Result,
    output logic              Carry_Flag,
    output logic              Zero_Flag,
    output logic              Done
);

    localparam logic [2:0] OP_ADD = 3'b000;

    typedef enum logic [1:0] {IDLE, OPER, WB} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d, zero_q, zero_d;
    logic              ready_q, ready_d, done_q, done_d;
    logic              unused_instr_bits;

    // Low instruction nibble carries no information.
    assign unused_instr_bits = ^instr_if.Instr[3:0];

    // Next-state, decode and writeback.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rf_d     = rf_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (Load_En) begin
                    rf_d[Load_Addr] = Load_Data;
                end
                // ready_q is always 1 in IDLE, so Valid alone means accept.
                if (instr_if.Instr_Valid) begin
                    op_d    = instr_if.Instr[15:13];
                    rd_d    = instr_if.Instr[12:10];
                    rs1_d   = instr_if.Instr[9:7];
                    rs2_d   = instr_if.Instr[6:4];
                    state_d = OPER;
                end
            end
            OPER: begin
                rf_d[rd_q] = ALU_Out;
                result_d   = ALU_Out;
                zero_d     = ALU_Zero;
                // Carry is sticky across everything but ADD.
                if (op_q == OP_ADD) begin
                    carry_d = ALU_Carry;
                end
                state_d = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_d == WB);
    end

    // State and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            rf_q     <= rf_d;
        end
    end

    // Operands are only driven while the ALU result is being consumed.
    assign ALU_A    = (state_q == OPER) ? rf_q[rs1_q] : '0;
    assign ALU_B    = (state_q == OPER) ? rf_q[rs2_q] : '0;
    assign ALU_Code = op_q;

    assign Dbg_Data             = rf_q[Dbg_Addr];
    assign Result               = result_q;
    assign Carry_Flag           = carry_q;
    assign Zero_Flag            = zero_q;
    assign Done                 = done_q;
    assign instr_if.Instr_Ready = ready_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU, a scoreboard queue
// popped on Done, and a per-cycle latency/handshake model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Load_En;
    logic [2:0] Load_Addr, Dbg_Addr, ALU_Code;
    logic [7:0] Load_Data, Dbg_Data, ALU_A, ALU_B, ALU_Out, Result;
    logic       ALU_Carry, ALU_Zero, Carry_Flag, Zero_Flag, Done;

    alu_issue_if u_if ();

    alu_issue_ctrl #(.NUM_REGS(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_if(u_if),
        .Load_En(Load_En), .Load_Addr(Load_Addr), .Load_Data(Load_Data),
        .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Code(ALU_Code),
        .ALU_Out(ALU_Out), .ALU_Carry(ALU_Carry), .ALU_Zero(ALU_Zero),
        .Result(Result), .Carry_Flag(Carry_Flag), .Zero_Flag(Zero_Flag),
        .Done(Done)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 PASS A.
    always_comb begin
        logic [8:0] w;
        case (ALU_Code)
            3'd0:    w = {1'b0, ALU_A} + {1'b0, ALU_B};
            3'd1:    w = {1'b0, ALU_A} - {1'b0, ALU_B};
            3'd2:    w = {1'b0, ALU_A & ALU_B};
            3'd3:    w = {1'b0, ALU_A | ALU_B};
            3'd4:    w = {1'b0, ALU_A ^ ALU_B};
            3'd5:    w = {1'b0, ~ALU_A};
            3'd6:    w = {ALU_A, 1'b0};
            default: w = {1'b0, ALU_A};
        endcase
        ALU_Out   = w[7:0];
        ALU_Carry = w[8];
        ALU_Zero  = (w[7:0] == 8'h00);
    end

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   acc_cnt     = 0;
    int   done_cnt    = 0;
    logic oper_exp, done_exp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'hA};
    endfunction

    // Expected sequencing: OPER the cycle after an accept, WB the one after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oper_exp <= 1'b0;
            done_exp <= 1'b0;
        end else begin
            oper_exp <= u_if.Instr_Valid && !oper_exp && !done_exp;
            done_exp <= oper_exp;
            if (u_if.Instr_Valid && u_if.Instr_Ready) acc_cnt++;
        end
    end

    // Per-cycle handshake/operand checks and scoreboard pop on Done.
    always @(negedge clk) begin
        check("done_timing", 16'(Done), 16'(done_exp));
        check("ready", 16'(u_if.Instr_Ready), 16'(!(oper_exp || done_exp)));
        if (!oper_exp) check("alu_ab_idle", {ALU_A, ALU_B}, 16'h0000);
        if (Done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 16'(Done), 16'h0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 16'(Result), 16'(e.res));
                check("carry", 16'(Carry_Flag), 16'(e.c));
                check("zero", 16'(Zero_Flag), 16'(e.z));
                check("rf_rd", 16'(Dbg_Data), 16'(e.res));
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        Load_En = 1'b1; Load_Addr = a; Load_Data = d;
        @(negedge clk);
        Load_En = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] r, input logic c, input logic z);
        @(negedge clk);
        u_if.Instr_Valid = 1'b1;
        u_if.Instr       = enc(op, rd, rs1, rs2);
        Dbg_Addr         = rd;
        exp_q.push_back('{res: r, c: c, z: z});
        @(negedge clk);
        u_if.Instr_Valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic dbg(input logic [2:0] a, input logic [7:0] e);
        @(negedge clk);
        Dbg_Addr = a;
        #1 check("dbg_rf", 16'(Dbg_Data), 16'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0;
        rst_n = 1'b0; Load_En = 1'b0; Load_Addr = '0; Load_Data = '0; Dbg_Addr = '0;
        u_if.Instr_Valid = 1'b0; u_if.Instr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_result", 16'(Result), 16'h0000);
        check("rst_flags", {14'h0, Carry_Flag, Zero_Flag}, 16'h0000);
        check("rst_ready", 16'(u_if.Instr_Ready), 16'h0001);
        for (int i = 0; i < 8; i++) dbg(3'(i), 8'h00);

        load(3'd1, 8'hF0);
        load(3'd2, 8'h20);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h10, 1'b1, 1'b0);   // ADD r3 = F0+20
        issue(3'd1, 3'd4, 3'd1, 3'd1, 8'h00, 1'b1, 1'b1);   // SUB r4 = r1-r1, carry held
        issue(3'd0, 3'd5, 3'd2, 3'd2, 8'h40, 1'b0, 1'b0);   // ADD r5 = 20+20
        issue(3'd5, 3'd6, 3'd1, 3'd0, 8'h0F, 1'b0, 1'b0);   // NOT r6 = ~F0
        issue(3'd4, 3'd7, 3'd1, 3'd2, 8'hD0, 1'b0, 1'b0);   // XOR r7 = F0^20

        // Valid held across six edges: accepted exactly at edges 0 and 3.
        a0 = acc_cnt; d0 = done_cnt;
        @(negedge clk);
        u_if.Instr_Valid = 1'b1;
        u_if.Instr       = enc(3'd0, 3'd0, 3'd2, 3'd2);
        Dbg_Addr         = 3'd0;
        exp_q.push_back('{res: 8'h40, c: 1'b0, z: 1'b0});
        exp_q.push_back('{res: 8'h40, c: 1'b0, z: 1'b0});
        repeat (6) @(negedge clk);
        u_if.Instr_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_accepts", 16'(acc_cnt - a0), 16'd2);
        check("hold_dones", 16'(done_cnt - d0), 16'd2);

        // Load r1=05 on the same edge as accepting ADD r2 = r1+r1.
        @(negedge clk);
        Load_En = 1'b1; Load_Addr = 3'd1; Load_Data = 8'h05;
        u_if.Instr_Valid = 1'b1;
        u_if.Instr       = enc(3'd0, 3'd2, 3'd1, 3'd1);
        Dbg_Addr         = 3'd2;
        exp_q.push_back('{res: 8'h0A, c: 1'b0, z: 1'b0});
        @(negedge clk);
        Load_En = 1'b0; u_if.Instr_Valid = 1'b0;
        repeat (2) @(negedge clk);

        // Load during OPER must be dropped.
        @(negedge clk);
        u_if.Instr_Valid = 1'b1;
        u_if.Instr       = enc(3'd0, 3'd0, 3'd2, 3'd2);
        Dbg_Addr         = 3'd0;
        exp_q.push_back('{res: 8'h14, c: 1'b0, z: 1'b0});
        @(negedge clk);
        u_if.Instr_Valid = 1'b0;
        Load_En = 1'b1; Load_Addr = 3'd7; Load_Data = 8'h55;
        @(negedge clk);
        Load_En = 1'b0;
        @(negedge clk);
        dbg(3'd7, 8'hD0);
        dbg(3'd3, 8'h10);
        dbg(3'd4, 8'h00);
        dbg(3'd5, 8'h40);
        dbg(3'd6, 8'h0F);
        dbg(3'd1, 8'h05);

        // Reset during OPER of ADD r3 = r1+r2 aborts it.
        d0 = done_cnt;
        @(negedge clk);
        u_if.Instr_Valid = 1'b1;
        u_if.Instr       = enc(3'd0, 3'd3, 3'd1, 3'd2);
        @(negedge clk);
        u_if.Instr_Valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_done", 16'(done_cnt - d0), 16'd0);
        check("rst2_result", 16'(Result), 16'h0000);
        check("rst2_flags", {14'h0, Carry_Flag, Zero_Flag}, 16'h0000);
        check("rst2_ready", 16'(u_if.Instr_Ready), 16'h0001);
        dbg(3'd3, 8'h00);
        dbg(3'd7, 8'h00);

        check("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
